// File: rtl/squeeze_layer_engine.sv
// squeeze_layer_engine: MAC-array engine for squeeze (1x1) and KxK conv layers.
// DSP_NO lanes accumulate KERNEL_DIM^2*CHIN beats each, then add bias,
// requantise (arithmetic shift by FRAC), apply ReLU and saturate to WIDTH bits.
// Pipeline: product -> accumulate -> requantise/register, fixed latency 3.
// Optional macro ROUNDING_EN: round-half-up before the shift instead of truncation.

// One MAC lane: product register, accumulator, requantised output register.
module squeeze_lane #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 14,
  parameter int ACC_W = 2*WIDTH+8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      p_en,
  input  logic                      acc_en,
  input  logic                      acc_first,
  input  logic                      out_en,
  input  logic signed [WIDTH-1:0]   ifm,
  input  logic signed [WIDTH-1:0]   kernel,
  input  logic signed [2*WIDTH-1:0] bias,
  output logic        [WIDTH-1:0]   ofm
);
  localparam logic signed [ACC_W-1:0] MAXV = (ACC_W'(1) << (WIDTH-1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] RND  = ACC_W'(1) << (FRAC-1);

  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   acc, pext, bext, sum, shf;
  logic        [WIDTH-1:0]   sat;

  assign pext = {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
  assign bext = {{(ACC_W-2*WIDTH){bias[2*WIDTH-1]}}, bias};

  // stage 1: full-precision signed product of the accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    prod <= '0;
    else if (p_en) prod <= $signed({{WIDTH{ifm[WIDTH-1]}}, ifm}) *
                           $signed({{WIDTH{kernel[WIDTH-1]}}, kernel});
  end

  // stage 2: accumulate; first beat of a pixel restarts the sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      acc <= '0;
    else if (acc_en) acc <= acc_first ? pext : acc + pext;
  end

  // bias, requantising shift, ReLU, saturation
  always_comb begin
`ifdef ROUNDING_EN
    sum = acc + bext + RND;
`else
    sum = acc + bext;
`endif
    shf = sum >>> FRAC;
    sat = shf[WIDTH-1:0];
    if (shf[ACC_W-1])   sat = '0;
    else if (shf > MAXV) sat = MAXV[WIDTH-1:0];
  end

  // stage 3: output register, holds between samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ofm <= '0;
    else if (out_en) ofm <= sat;
  end
endmodule

module squeeze_layer_engine #(
  parameter int WIDTH      = 16,
  parameter int DSP_NO     = 112,
  parameter int CHIN       = 384,
  parameter int KERNEL_DIM = 3,
  parameter int WOUT       = 8,
  parameter int FRAC       = 14,
  parameter int ACC_W      = 2*WIDTH+8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             layer_en,
  input  logic [WIDTH-1:0]                 ifm,
  input  logic                             ifm_valid,
  input  logic [DSP_NO-1:0][WIDTH-1:0]     kernels,
  input  logic [DSP_NO-1:0][2*WIDTH-1:0]   bias,
  input  logic                             ram_feedback,
  output logic                             rom_clr_pulse_o,
  output logic                             ofm_sample,
  output logic [DSP_NO-1:0][WIDTH-1:0]     ofm,
  output logic                             busy,
  output logic                             layer_finish
);
  localparam int ACC_LEN = KERNEL_DIM*KERNEL_DIM*CHIN;
  localparam int NPIX    = WOUT*WOUT;
  localparam int TAP_W   = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam int PIX_W   = $clog2(NPIX+1);
  localparam int STAGES  = 3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t state, state_nx;

  logic [TAP_W-1:0]  tap_cnt;
  logic [PIX_W-1:0]  in_cnt, pix_cnt;
  logic              fb_seen, first_p;
  logic [STAGES:0]   vld_pipe, last_pipe;
  logic              accept, tap_last, last_pix, final_smp;

  assign accept    = (state == S_RUN) && ifm_valid;
  assign tap_last  = tap_cnt == TAP_W'(ACC_LEN-1);
  assign last_pix  = in_cnt == PIX_W'(NPIX-1);
  assign final_smp = ofm_sample && (pix_cnt == PIX_W'(NPIX-1));

  assign vld_pipe[0]     = accept;
  assign last_pipe[0]    = tap_last;
  assign ofm_sample      = vld_pipe[STAGES] & last_pipe[STAGES];
  assign rom_clr_pulse_o = accept && tap_last;
  assign busy            = (state == S_RUN) || (state == S_DRAIN);
  assign layer_finish    = (state == S_DONE) && !fb_seen;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // next state; layer_en low overrides everything
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (layer_en) state_nx = S_RUN;
      S_RUN:   if (accept && tap_last && last_pix) state_nx = S_DRAIN;
      S_DRAIN: if (final_smp) state_nx = S_DONE;
      S_DONE:  state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
    if (!layer_en) state_nx = S_IDLE;
  end

  // beat / issued-pixel / sampled-pixel counters, cleared whenever heading to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_cnt <= '0;
      in_cnt  <= '0;
      pix_cnt <= '0;
    end else if (state_nx == S_IDLE) begin
      tap_cnt <= '0;
      in_cnt  <= '0;
      pix_cnt <= '0;
    end else begin
      if (accept)            tap_cnt <= tap_last ? '0 : tap_cnt + 1'b1;
      if (accept && tap_last) in_cnt <= in_cnt + 1'b1;
      if (ofm_sample)        pix_cnt <= pix_cnt + 1'b1;
    end
  end

  // completion ack; feedback landing on the DONE entry cycle also counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   fb_seen <= 1'b0;
    else if (state_nx == S_IDLE)                  fb_seen <= 1'b0;
    else if (ram_feedback && state_nx == S_DONE)  fb_seen <= 1'b1;
  end

  // valid/last shift register; abort flushes in-flight beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[STAGES:1]  <= '0;
      last_pipe[STAGES:1] <= '0;
      first_p             <= 1'b0;
    end else if (!layer_en) begin
      vld_pipe[STAGES:1]  <= '0;
      last_pipe[STAGES:1] <= '0;
      first_p             <= 1'b0;
    end else begin
      vld_pipe[STAGES:1]  <= vld_pipe[STAGES-1:0];
      last_pipe[STAGES:1] <= last_pipe[STAGES-1:0];
      first_p             <= tap_cnt == '0;
    end
  end

  for (genvar g = 0; g < DSP_NO; g++) begin : g_lane
    squeeze_lane #(.WIDTH(WIDTH), .FRAC(FRAC), .ACC_W(ACC_W)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .p_en     (vld_pipe[0]),
      .acc_en   (vld_pipe[1]),
      .acc_first(first_p),
      .out_en   (vld_pipe[2] & last_pipe[2] & layer_en),
      .ifm      (ifm),
      .kernel   (kernels[g]),
      .bias     (bias[g]),
      .ofm      (ofm[g])
    );
  end
endmodule

// File: tb/tb_squeeze_layer_engine.sv
// Directed bench for squeeze_layer_engine: 2 lanes, 2 beats/pixel, 4 pixels/layer.
module tb_squeeze_layer_engine;
  localparam int WIDTH = 16;
`ifdef ROUNDING_EN
  localparam logic [15:0] RND_EXP = 16'h0001;
`else
  localparam logic [15:0] RND_EXP = 16'h0000;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n, layer_en, ifm_valid, ram_feedback;
  logic [15:0]          ifm;
  logic [1:0][15:0]     kernels;
  logic [1:0][31:0]     bias;
  logic                 rom_clr_pulse_o, ofm_sample, busy, layer_finish;
  logic [1:0][15:0]     ofm;

  int checks = 0, errors = 0, edges = 0, rom_cnt = 0;
  logic [15:0] s0_q[$], s1_q[$];
  int          se_q[$];

  squeeze_layer_engine #(.WIDTH(16), .DSP_NO(2), .CHIN(2), .KERNEL_DIM(1),
                         .WOUT(2), .FRAC(14)) dut (
    .clk(clk), .rst_n(rst_n), .layer_en(layer_en), .ifm(ifm), .ifm_valid(ifm_valid),
    .kernels(kernels), .bias(bias), .ram_feedback(ram_feedback),
    .rom_clr_pulse_o(rom_clr_pulse_o), .ofm_sample(ofm_sample), .ofm(ofm),
    .busy(busy), .layer_finish(layer_finish));

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  // record every output sample and rewind strobe
  always @(negedge clk) begin
    if (ofm_sample) begin
      s0_q.push_back(ofm[0]);
      s1_q.push_back(ofm[1]);
      se_q.push_back(edges);
    end
    if (rom_clr_pulse_o) rom_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // drop layer_en for one cycle, then re-enable for a fresh run
  task automatic new_run();
    cyc(); layer_en = 1'b0;
    cyc(); layer_en = 1'b1;
  endtask

  // one full layer: 4 pixels, valid pattern pat[0..plen-1] per pixel
  task automatic run_layer(input string tag, input logic [15:0] x, k0, k1,
                           input logic [31:0] b, input logic [3:0] pat, input int plen,
                           input logic [15:0] e0, e1);
    int ae[$];
    int rb, beat, budget;
    rb = rom_cnt;
    s0_q.delete(); s1_q.delete(); se_q.delete();
    ifm = x; kernels = {k1, k0}; bias = {b, b};
    for (int p = 0; p < 4; p++) begin
      beat = 0;
      for (int i = 0; i < plen; i++) begin
        cyc();
        ifm_valid = pat[i];
        if (pat[i]) begin
          beat++;
          if (beat == 2) ae.push_back(edges + 1);
        end
      end
    end
    cyc(); ifm_valid = 1'b0;
    budget = 0;
    while (se_q.size() < 4 && budget < 40) begin
      @(negedge clk); #1; budget++;
    end
    chk({tag, "_nsmp"}, se_q.size(), 4);
    for (int i = 0; i < se_q.size() && i < 4; i++) begin
      chk({tag, "_l0"}, s0_q[i], e0);
      chk({tag, "_l1"}, s1_q[i], e1);
      chk({tag, "_lat"}, se_q[i] - ae[i], 2);
    end
    chk({tag, "_fin_early"}, layer_finish, 1'b0);
    @(negedge clk); #1;
    chk({tag, "_fin"}, layer_finish, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_romclr"}, rom_cnt - rb, 4);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; layer_en = 1'b0; ifm_valid = 1'b0; ram_feedback = 1'b0;
    ifm = '0; kernels = '0; bias = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_ofm", ofm, 32'h0);
    chk("rst_smp", ofm_sample, 1'b0);
    chk("rst_rom", rom_clr_pulse_o, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fin", layer_finish, 1'b0);

    cyc(); rst_n = 1'b1;
    cyc(); layer_en = 1'b1;
    run_layer("basic", 16'h4000, 16'h2000, 16'h2000, 32'h0, 4'b0011, 2, 16'h4000, 16'h4000);

    // completion acknowledge
    cyc(); ram_feedback = 1'b1;
    cyc(); ram_feedback = 1'b0;
    @(negedge clk);
    chk("fb_fin", layer_finish, 1'b0);

    new_run();
    run_layer("rerun", 16'h4000, 16'h2000, 16'h2000, 32'h0, 4'b0011, 2, 16'h4000, 16'h4000);
    new_run();
    run_layer("relu", 16'h4000, 16'h2000, 16'hE000, 32'h0, 4'b0011, 2, 16'h4000, 16'h0000);
    new_run();
    run_layer("sat", 16'h7FFF, 16'h7FFF, 16'h7FFF, 32'h0, 4'b0011, 2, 16'h7FFF, 16'h7FFF);
    new_run();
    run_layer("stall", 16'h4000, 16'h2000, 16'h2000, 32'h0, 4'b1001, 4, 16'h4000, 16'h4000);

    // abort mid-pixel: in-flight beat must not produce a sample
    new_run();
    ifm = 16'h4000; kernels = {16'h2000, 16'h2000};
    cyc(); ifm_valid = 1'b1;
    cyc(); ifm_valid = 1'b0; layer_en = 1'b0;
    n = se_q.size();
    repeat (6) @(negedge clk);
    chk("abort_nosmp", se_q.size(), n);
    chk("abort_busy", busy, 1'b0);
    cyc(); layer_en = 1'b1;
    run_layer("post_abort", 16'h4000, 16'h2000, 16'h2000, 32'h0, 4'b0011, 2, 16'h4000, 16'h4000);

    // reset mid-pixel clears outputs that were non-zero
    new_run();
    cyc(); ifm_valid = 1'b1;
    cyc(); ifm_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_ofm", ofm, 32'h0);
    chk("mrst_smp", ofm_sample, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_fin", layer_finish, 1'b0);
    cyc(); rst_n = 1'b1; layer_en = 1'b0;
    cyc(); layer_en = 1'b1;
    run_layer("round", 16'h0000, 16'h0000, 16'h0000, 32'h2000, 4'b0011, 2, RND_EXP, RND_EXP);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/squeeze_layer_engine.md
# squeeze_layer_engine

Parametrised MAC-array engine for squeeze/1x1 and KxK convolution layers. It accumulates DSP_NO output channels in parallel over KERNEL_DIM²·CHIN input beats, then adds per-channel bias and applies ReLU, requantisation and saturation. It produces WOUT² output pixels per layer run and sits between the IFM buffer/kernel ROM and the OFM RAM. Compared with the fixed per-layer blocks it adds input stall support, signed saturation, re-runnable completion and abort.

## Interface
- WIDTH, 16: ifm/kernel/ofm width, signed two's complement.
- DSP_NO, 112: parallel output channels (MAC lanes).
- CHIN, 384: input channels.
- KERNEL_DIM, 3: kernel side; 1 for squeeze layers.
- WOUT, 8: output feature-map side; the layer produces WOUT² pixels.
- FRAC, 14: requantisation right-shift, 1 ≤ FRAC < 2·WIDTH.
- ACC_W, 2*WIDTH+8: accumulator width (guard bits).
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- layer_en  in  1  level enable; a 0 in any state returns the block to IDLE.
- ifm  in  WIDTH  input pixel beat.
- ifm_valid  in  1  ifm and kernels are valid this cycle.
- kernels  in  WIDTH×DSP_NO  per-lane weight for the current beat.
- bias  in  2·WIDTH×DSP_NO  per-lane signed bias, same Q format as products; static during a run.
- ram_feedback  in  1  OFM RAM acknowledges layer completion.
- rom_clr_pulse_o  out  1  kernel-ROM address rewind strobe.
- ofm_sample  out  1  one-cycle strobe: ofm updated this cycle.
- ofm  out  WIDTH×DSP_NO  output pixel, all lanes.
- busy  out  1  state is RUN or DRAIN.
- layer_finish  out  1  layer done, not yet acknowledged.

## Operation
- ACC_LEN = KERNEL_DIM²·CHIN. A beat is accepted when state==RUN && ifm_valid.
- States:
  - IDLE→RUN when layer_en=1.
  - RUN→DRAIN when the last beat of pixel WOUT²−1 is accepted.
  - DRAIN→DONE on the final ofm_sample.
  - DONE→IDLE when layer_en=0.
  - Any state→IDLE when layer_en=0. The pipeline flushes, no ofm_sample is issued for the partial pixel, and all counters are cleared.
- tap_cnt: counts accepted beats 0..ACC_LEN−1, wraps to 0. pix_cnt: counts ofm_sample pulses 0..WOUT².
- rom_clr_pulse_o is combinational: accepted beat && tap_cnt==ACC_LEN−1.
- Stage 1: p[i] = signed ifm × signed kernels[i] (2·WIDTH bits), registered with valid/first/last flags.
- Stage 2: on valid, acc[i] = first ? sext(p[i]) : acc[i]+sext(p[i]). The acc holds when there is no valid beat.
- Stage 3, after the last beat: s = acc + sext(bias). Then t = s >>> FRAC (arithmetic). ReLU: t<0 → 0. Saturate: t > 2^(WIDTH−1)−1 → 2^(WIDTH−1)−1. The result is registered into ofm[i] together with ofm_sample=1.
- layer_finish = (state==DONE) && !fb_seen. fb_seen is set by ram_feedback only while in DONE and is cleared on the exit to IDLE.
- ofm holds its value between samples.

## Timing
- Reset values: ofm all 0, ofm_sample 0, rom_clr_pulse_o 0, busy 0, layer_finish 0. State, counters, acc and fb_seen are cleared.
- Last beat of a pixel accepted in cycle t: product in t+1, acc final in t+2, ofm valid and ofm_sample=1 in t+3. Fixed latency 3.
- Back-to-back pixels at ifm_valid=1 every cycle: one ofm_sample every ACC_LEN cycles, with no bubble between pixels.
- ifm_valid=0 stalls only the input. In-flight beats still complete.
- ram_feedback outside DONE is ignored. If ram_feedback arrives in the same cycle DONE is entered, layer_finish stays 0.
- layer_finish rises one cycle after the final ofm_sample.
- Deasserting rst_n mid-operation clears everything immediately. After release the block is in IDLE and waits for layer_en.

## Configuration
- ROUNDING_EN defined: t = (s + 2^(FRAC−1)) >>> FRAC, round-half-up, applied before ReLU and saturation.
- ROUNDING_EN undefined: plain truncating arithmetic shift.

## Test plan
All tests use WIDTH=16, FRAC=14, DSP_NO=2, CHIN=2, KERNEL_DIM=1, WOUT=2, and ROUNDING_EN undefined unless stated.
- Basic: ifm=0x4000, kernels=0x2000, bias=0, ifm_valid continuous → ofm=0x4000 on both lanes, 3 cycles after each second beat. rom_clr_pulse_o occurs once per pixel.
- ReLU: kernels[1]=0xE000, others as in the basic test → ofm[1]=0x0000 and ofm[0]=0x4000.
- Saturation: ifm=0x7FFF, kernels=0x7FFF → ofm=0x7FFF on both lanes.
- Stall: ifm_valid pattern 1,0,0,1 per pixel → same values as the basic test, with ofm_sample exactly 3 cycles after the second accepted beat.
- Completion:
  - After 4 ofm_sample pulses, busy=0 and layer_finish=1.
  - A ram_feedback pulse drops layer_finish to 0.
  - layer_en low then high → a second full run with identical outputs.
- Abort, reset and rounding:
  - layer_en=0 mid-pixel → no ofm_sample, and the next run is correct.
  - rst_n pulse mid-pixel → all outputs 0.
  - Products 0 with bias=0x2000 → ofm=0 when truncating, ofm=1 with ROUNDING_EN.
